// File: rtl/wb_master_arb.sv
// Round-robin arbiter giving MASTERS Wishbone masters one at a time access to a shared bus.
// Optional watchdog on a stalled strobe is enabled by defining WB_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no tenure; shared bus driven low, next winner picked
// ST_BUSY | master gnt owns the bus until it drops its cyc

module wb_master_arb #(
    parameter int MASTERS = 4,
    parameter int AW      = 28,
    parameter int TIMEOUT = 255,
    localparam int DW     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [MASTERS-1:0]    m_cyc_i,
    input  logic [MASTERS-1:0]    m_stb_i,
    input  logic [MASTERS-1:0]    m_we_i,
    input  logic [MASTERS*4-1:0]  m_sel_i,
    input  logic [MASTERS*AW-1:0] m_adr_i,
    input  logic [MASTERS*DW-1:0] m_dat_i,
    output logic [MASTERS-1:0]    m_ack_o,
    output logic [MASTERS-1:0]    m_err_o,
    output logic [DW-1:0]         m_dat_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [3:0]            s_sel_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW-1:0]         s_dat_o,
    input  logic                  s_ack_i,
    input  logic [DW-1:0]         s_dat_i
);

    localparam int GW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    if (MASTERS < 2 || MASTERS > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("wb_master_arb: MASTERS or TIMEOUT out of range");
    end

    logic [0:0]    state;
    logic [GW-1:0] gnt;
    logic [GW-1:0] last;
    logic [GW-1:0] nxt_gnt;
    logic          found;
    logic          busy;
    logic          wdt_hit;
    int            rr_idx;

    assign busy    = (state == ST_BUSY);
    assign m_dat_o = s_dat_i;

    // Scan starts just after the previous owner, so it naturally gets lowest priority.
    always_comb begin
        nxt_gnt = gnt;
        found   = 1'b0;
        rr_idx  = 0;
        for (int k = 1; k <= MASTERS; k++) begin
            rr_idx = int'(last) + k;
            if (rr_idx >= MASTERS) rr_idx = rr_idx - MASTERS;
            if (!found && m_cyc_i[rr_idx]) begin
                found   = 1'b1;
                nxt_gnt = GW'(rr_idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
            gnt   <= '0;
            last  <= GW'(MASTERS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        gnt   <= nxt_gnt;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!m_cyc_i[gnt]) begin
                        last  <= gnt;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        if (busy) begin
            s_cyc_o      = m_cyc_i[gnt];
            s_stb_o      = m_stb_i[gnt] & ~wdt_hit;
            s_we_o       = m_we_i[gnt];
            s_sel_o      = m_sel_i[gnt*4 +: 4];
            s_adr_o      = m_adr_i[gnt*AW +: AW];
            s_dat_o      = m_dat_i[gnt*DW +: DW];
            m_ack_o[gnt] = s_ack_i & m_stb_i[gnt];
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WDT_W = (TIMEOUT < 256) ? 8 : 16;

    logic [WDT_W-1:0] wdt;

    assign wdt_hit = busy && (wdt == WDT_W'(TIMEOUT));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wdt <= '0;
        end else if (!busy || s_ack_i || wdt_hit) begin
            wdt <= '0;
        end else if (s_stb_o) begin
            wdt <= wdt + 1'b1;
        end
    end

    always_comb begin
        m_err_o = '0;
        if (wdt_hit) m_err_o[gnt] = 1'b1;
    end
`else
    assign wdt_hit = 1'b0;
    assign m_err_o = '0;
`endif

endmodule

// File: tb/tb_wb_master_arb.sv
// Scoreboard bench for wb_master_arb (default build, watchdog disabled):
// expected grant order is queued as requests are raised and checked at each new tenure.

module tb_wb_master_arb;

    localparam int MASTERS = 4;
    localparam int AW      = 28;
    localparam int DW      = 32;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b0;
    logic [MASTERS-1:0]    m_cyc_i = '0;
    logic [MASTERS-1:0]    m_stb_i = '0;
    logic [MASTERS-1:0]    m_we_i  = '0;
    logic [MASTERS*4-1:0]  m_sel_i = '0;
    logic [MASTERS*AW-1:0] m_adr_i = '0;
    logic [MASTERS*DW-1:0] m_dat_i = '0;
    logic [MASTERS-1:0]    m_ack_o;
    logic [MASTERS-1:0]    m_err_o;
    logic [DW-1:0]         m_dat_o;
    logic                  s_cyc_o;
    logic                  s_stb_o;
    logic                  s_we_o;
    logic [3:0]            s_sel_o;
    logic [AW-1:0]         s_adr_o;
    logic [DW-1:0]         s_dat_o;
    logic                  s_ack_i = 1'b0;
    logic [DW-1:0]         s_dat_i = '0;

    int n_cmp = 0;
    int n_err = 0;
    int exp_gnt_q[$];

    wb_master_arb #(.MASTERS(MASTERS), .AW(AW), .TIMEOUT(16)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_sel_i (m_sel_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_sel_o (s_sel_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_ack_i (s_ack_i),
        .s_dat_i (s_dat_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [AW-1:0] adr_of(input int i);
        return AW'(28'h0100ABC + i * 28'h0101010);
    endfunction

    function automatic logic [DW-1:0] dat_of(input int i);
        return 32'hC0DE_0000 + 32'(i * 32'h0000_0111);
    endfunction

    function automatic logic [3:0] sel_of(input int i);
        return 4'hF ^ 4'(i + 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v);
        m_cyc_i[i] = v;
        m_stb_i[i] = v;
    endtask

    // Called at the negedge where the request is (or already was) raised.
    task automatic wait_grant(input string tag, output int g);
        int k;
        @(negedge clk_i);
        k = 1;
        while (!s_cyc_o && k < 8) begin
            @(negedge clk_i);
            k++;
        end
        chk({tag, "_latency"}, 64'(k), 64'd1);
        chk({tag, "_cyc"}, 64'(s_cyc_o), 64'd1);
        if (exp_gnt_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
            g = 0;
        end else begin
            g = exp_gnt_q.pop_front();
            chk({tag, "_adr"}, 64'(s_adr_o), 64'(adr_of(g)));
            chk({tag, "_dat"}, 64'(s_dat_o), 64'(dat_of(g)));
            chk({tag, "_sel"}, 64'(s_sel_o), 64'(sel_of(g)));
        end
    endtask

    // Ack one strobe of master g, then release; returns at the IDLE negedge.
    task automatic end_tenure(input string tag, input int g);
        logic [DW-1:0] d;
        d = $urandom;
        s_ack_i = 1'b1;
        s_dat_i = d;
        #1;
        chk({tag, "_ack"}, 64'(m_ack_o), 64'(4'b0001 << g));
        chk({tag, "_rdat"}, 64'(m_dat_o), 64'(d));
        @(negedge clk_i);
        s_ack_i = 1'b0;
        set_req(g, 1'b0);
        #1;
        chk({tag, "_drop_cyc"}, 64'({s_cyc_o, s_stb_o}), 64'd0);
        @(negedge clk_i);
        chk({tag, "_idle_gap"}, 64'({s_cyc_o, m_ack_o}), 64'd0);
    endtask

    initial begin
        int g;
        int bad;

        for (int i = 0; i < MASTERS; i++) begin
            m_adr_i[i*AW +: AW] = adr_of(i);
            m_dat_i[i*DW +: DW] = dat_of(i);
            m_sel_i[i*4 +: 4]   = sel_of(i);
        end

        // Held in reset with every master requesting: nothing may be granted.
        m_cyc_i = '1;
        m_stb_i = '1;
        s_ack_i = 1'b1;
        #2;
        chk("rst_bus", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o}), 64'd0);
        chk("rst_term", 64'({m_ack_o, m_err_o}), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_hold", 64'({s_cyc_o, m_ack_o}), 64'd0);
        s_ack_i = 1'b0;

        // Round robin with all four contending: 0,1,2,3,0.
        exp_gnt_q.push_back(0);
        exp_gnt_q.push_back(1);
        exp_gnt_q.push_back(2);
        exp_gnt_q.push_back(3);
        exp_gnt_q.push_back(0);
        rst_i = 1'b1;
        for (int t = 0; t < 5; t++) begin
            wait_grant("rr", g);
            end_tenure("rr", g);
            if (t < 4) set_req(g, 1'b1);
            else begin
                m_cyc_i = '0;
                m_stb_i = '0;
            end
        end

        // Master 2 owns the bus while master 1 waits.
        exp_gnt_q.push_back(2);
        exp_gnt_q.push_back(1);
        set_req(2, 1'b1);
        wait_grant("m2", g);
        set_req(1, 1'b1);
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEADBEEF;
        #1;
        chk("m2_ack", 64'(m_ack_o), 64'(4'b0100));
        chk("m2_rdat", 64'(m_dat_o), 64'h0000_0000_DEAD_BEEF);
        @(negedge clk_i);
        m_stb_i[2] = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (m_ack_o != '0 || m_err_o != '0 || s_adr_o != adr_of(2)) bad++;
        end
        chk("m1_held_off", 64'(bad), 64'd0);
        s_ack_i = 1'b0;
        m_stb_i[2] = 1'b1;
        end_tenure("m2", 2);
        wait_grant("m1", g);
        end_tenure("m1", g);

        // Master 0 locks the bus over read, read, write strobes.
        exp_gnt_q.push_back(0);
        m_cyc_i[0] = 1'b1;
        wait_grant("lock", g);
        for (int s = 0; s < 3; s++) begin
            m_we_i[0]  = (s == 2);
            m_stb_i[0] = 1'b1;
            s_ack_i    = 1'b1;
            #1;
            chk("lock_we", 64'(s_we_o), 64'(s == 2));
            chk("lock_ack", 64'({s_stb_o, m_ack_o}), 64'({1'b1, 4'b0001}));
            @(negedge clk_i);
            s_ack_i    = 1'b0;
            m_stb_i[0] = 1'b0;
            #1;
            chk("lock_gap", 64'({s_cyc_o, s_stb_o, s_adr_o}), 64'({1'b1, 1'b0, adr_of(0)}));
            @(negedge clk_i);
        end
        m_we_i[0]  = 1'b0;
        m_stb_i[0] = 1'b1;
        // Stalled strobe with no watchdog built in: no error, bus stays owned.
        bad = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (m_err_o != '0 || !s_stb_o || s_adr_o != adr_of(0)) bad++;
        end
        chk("no_err_stall", 64'(bad), 64'd0);
        end_tenure("lock", 0);

        // A lone requester is re-granted after every idle cycle.
        exp_gnt_q.push_back(3);
        exp_gnt_q.push_back(3);
        for (int r = 0; r < 2; r++) begin
            set_req(3, 1'b1);
            wait_grant("solo", g);
            end_tenure("solo", g);
        end

        // Reset in the middle of a tenure aborts it with no termination.
        exp_gnt_q.push_back(2);
        set_req(2, 1'b1);
        wait_grant("abort", g);
        set_req(0, 1'b1);
        set_req(1, 1'b1);
        s_ack_i = 1'b1;
        #2;
        rst_i = 1'b0;
        #1;
        chk("abort_bus", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o}), 64'd0);
        chk("abort_term", 64'({m_ack_o, m_err_o}), 64'd0);
        @(negedge clk_i);
        s_ack_i = 1'b0;
        m_cyc_i = '1;
        m_stb_i = '1;
        exp_gnt_q.push_back(0);
        rst_i = 1'b1;
        wait_grant("post_rst", g);
        end_tenure("post_rst", g);
        m_cyc_i = '0;
        m_stb_i = '0;

        chk("sb_drained", 64'(exp_gnt_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_master_arb.md
WB_MASTER_ARB -- requirements
Module: wb_master_arb

Interface
REQ-001 Parameter MASTERS, default 4: number of requesting Wishbone masters (2..16).
REQ-002 Parameter AW, default 28: address width; DW fixed at 32 (localparam).
REQ-003 Parameter TIMEOUT, default 255: watchdog limit in cycles (used only under REQ-024).
REQ-004 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-low reset.
REQ-006 m_cyc_i  in  MASTERS  per-master bus-cycle request.
REQ-007 m_stb_i / m_we_i  in  MASTERS each  per-master strobe / write enable.
REQ-008 m_sel_i  in  MASTERS*4; m_adr_i  in  MASTERS*AW; m_dat_i  in  MASTERS*DW  packed per master, master i at slice i.
REQ-009 m_ack_o / m_err_o  out  MASTERS each  per-master termination.
REQ-010 m_dat_o  out  DW  read data, broadcast to all masters.
REQ-011 s_cyc_o, s_stb_o, s_we_o  out  1; s_sel_o  out  4; s_adr_o  out  AW; s_dat_o  out  DW  shared bus toward the address decoder.
REQ-012 s_ack_i  in  1; s_dat_i  in  DW  shared bus response.

Function
REQ-013 Two states: IDLE, BUSY; state, grant index gnt and round-robin pointer last are registered.
REQ-014 IDLE: when any m_cyc_i is high, gnt SHALL take the first requesting index after last (cyclic, ascending), state -> BUSY next edge; arbitration latency exactly 1 cycle.
REQ-015 IDLE: all s_* outputs 0, all m_ack_o/m_err_o 0.
REQ-016 BUSY: s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o SHALL combinationally mirror master gnt's signals.
REQ-017 BUSY: m_ack_o[gnt] = s_ack_i & m_stb_i[gnt]; all other m_ack_o bits 0.
REQ-018 m_dat_o = s_dat_i at all times.
REQ-019 BUSY persists while m_cyc_i[gnt] high (bus locked across multiple strobes, incl. RMW).
REQ-020 m_cyc_i[gnt] low in BUSY: s_cyc_o/s_stb_o drop same cycle, last <= gnt, state -> IDLE; no re-grant in the same cycle (min one IDLE cycle between tenures).
REQ-021 Requests from non-granted masters SHALL be held off (no ack/err) regardless of duration.
REQ-022 Simultaneous requests in IDLE: only the round-robin winner is granted; a master released in REQ-020 is lowest priority next arbitration.
REQ-023 Single requester repeatedly asserting cyc SHALL be re-granted after each IDLE cycle.

Configuration
REQ-024 Macro WB_ARB_TIMEOUT_EN defined: 8..16-bit counter wdt clears in IDLE and on s_ack_i; increments each BUSY cycle with s_stb_o high and s_ack_i low; on reaching TIMEOUT, m_err_o[gnt] pulses high for 1 cycle, s_stb_o forced low that cycle, wdt clears.
REQ-025 Macro undefined: no counter instantiated, m_err_o tied to all zeros; port list unchanged.

Reset
REQ-026 rst_i low: immediately state=IDLE, gnt=0, last=MASTERS-1 (master 0 wins first), wdt=0, all s_* and m_ack_o/m_err_o 0.
REQ-027 Reset asserted mid-BUSY SHALL abort the tenure without any ack/err pulse; after release, arbitration restarts per REQ-014.

Verification
REQ-028 Reset, then m_cyc_i=4'b1111 -> first grant master 0, s_adr_o=m_adr_i slice 0 one cycle after request.
REQ-029 All four masters hold cyc, each drops after one ack -> grant order 0,1,2,3,0 with one IDLE cycle between.
REQ-030 Master 2 granted, master 1 requests; s_ack_i=1, s_dat_i=32'hDEADBEEF -> m_ack_o=4'b0100, m_dat_o=32'hDEADBEEF, master 1 held off.
REQ-031 Master 0 holds cyc for 3 strobes (read, read, write) -> grant never changes; s_we_o follows m_we_i[0].
REQ-032 WB_ARB_TIMEOUT_EN, TIMEOUT=16, s_ack_i stuck 0 -> m_err_o[gnt] single pulse 16 cycles after strobe; undefined -> no err ever.
REQ-033 rst_i pulled low during BUSY -> all outputs 0 asynchronously; post-reset grant goes to master 0.
